branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor feeding the next-PC mux and trained by the branch unit's resolved outcome (taken flag and target). It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and provides a same-cycle prediction for the current fetch PC. At resolution it compares the prediction against the actual outcome and issues a registered one-cycle redirect on mispredict. It also keeps saturating branch and mispredict statistics.

## Interface

- ADDR_WIDTH, 32, instruction address width (matches InsnAddrPath)
- INDEX_WIDTH, 4, log2 of BTB entry count (16 entries)
- clk  input  1  clock, all state updates on rising edge
- rstN  input  1  asynchronous, active-low reset
- fetchPC  input  ADDR_WIDTH  current fetch address (word aligned)
- predTaken  output  1  prediction for fetchPC (combinational from table state)
- predTarget  output  ADDR_WIDTH  predicted next PC for fetchPC
- flush  input  1  synchronous clear of all BTB valid bits
- updValid  input  1  resolved branch present this cycle
- updPC  input  ADDR_WIDTH  address of resolved branch
- updTaken  input  1  actual outcome (branch unit taken flag)
- updTarget  input  ADDR_WIDTH  actual taken target (branch unit target)
- updPredTaken  input  1  predTaken carried down the pipeline with this branch
- updPredTarget  input  ADDR_WIDTH  predTarget carried with this branch
- mispredict  output  1  registered one-cycle redirect pulse
- redirectPC  output  ADDR_WIDTH  registered correct next PC, valid when mispredict=1
- branchCount  output  32  saturating count of updValid cycles
- missCount  output  32  saturating count of mispredicts

## Operation

- Index = pc[INDEX_WIDTH+1:2]. Tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2]. Each entry holds valid, tag, target (ADDR_WIDTH), and ctr (2 bit).
- Lookup: hit = valid && tag match. predTaken = hit && ctr[1]. predTarget = target when predTaken, else fetchPC+4 (modulo 2^ADDR_WIDTH, wraps).
- Mispredict detection: miss = updValid && ((updTaken != updPredTaken) || (updTaken && updTarget != updPredTarget)).
- Correct PC: updTarget when updTaken, else updPC+4 (wraps).
- Training, on the edge when updValid=1 and flush=0:
  - On an update hit: ctr increments on taken and saturates at 3. ctr decrements on not-taken and saturates at 0. Target is overwritten with updTarget only when taken.
  - On an update miss with updTaken=1: allocate the entry. valid=1, tag=updPC tag, target=updTarget, ctr=2 (weakly taken). Any conflicting entry is replaced.
  - On an update miss with updTaken=0: no table change.
- Flush clears every valid bit. Targets and ctr are untouched. flush has priority over training in the same cycle. Counters and the mispredict pulse still act on that cycle's update.
- Statistics: branchCount increments on updValid. missCount increments on miss. Both hold at 0xFFFF_FFFF.

## Timing

- Prediction is zero latency: predTaken and predTarget reflect table state before the current edge.
- Same-cycle fetch and update to the same index: the read returns old contents. The new contents are visible from the next cycle.
- mispredict and redirectPC register on the edge where updValid is sampled. They are valid for exactly one cycle after it. mispredict returns to 0 the following cycle unless a new miss occurs.
- redirectPC holds its last value when mispredict=0.
- Back-to-back updates are accepted every cycle with no stall. There is no ready signal, and updValid is always consumed.
- Reset values (asserted asynchronously, released synchronously by the integrating logic):
  - all valid=0, ctr=1, target=0, tag=0
  - mispredict=0, redirectPC=0, branchCount=0, missCount=0
- Reset mid-update: the update is discarded, no pulse is produced, and the tables clear immediately.

## Test plan

- After reset, fetchPC=0x100 -> predTaken=0, predTarget=0x104. mispredict=0 and both counts 0.
- Update updPC=0x100, taken, target=0x200, predTaken=0 -> next cycle mispredict=1, redirectPC=0x200, missCount=1. Then fetchPC=0x100 -> predTaken=1, predTarget=0x200.
- Train 0x100 with taken, then three not-taken updates -> ctr goes 2→3→2→1→0. predTaken is 0 from the second not-taken onward. ctr holds at 0 on a further not-taken. Each update with a wrong updPredTaken pulses mispredict.
- Alias: allocate 0x100, then a taken update at 0x140 (INDEX_WIDTH=4, same index, different tag) -> fetchPC=0x100 now misses (predTarget=0x104). fetchPC=0x140 hits.
- Correct prediction: update with updTaken=updPredTaken=1 and matching target -> mispredict stays 0, branchCount increments, missCount is unchanged.
- Flush and update to the same entry in one cycle -> entry invalid afterwards, mispredict still pulses per the comparison. Then assert rstN=0 mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, same-cycle lookup, registered
// mispredict redirect and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [ADDR_WIDTH-1:0] fetchPC,
  output logic                  predTaken,
  output logic [ADDR_WIDTH-1:0] predTarget,
  input  logic                  flush,
  input  logic                  updValid,
  input  logic [ADDR_WIDTH-1:0] updPC,
  input  logic                  updTaken,
  input  logic [ADDR_WIDTH-1:0] updTarget,
  input  logic                  updPredTaken,
  input  logic [ADDR_WIDTH-1:0] updPredTarget,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirectPC,
  output logic [31:0]           branchCount,
  output logic [31:0]           missCount
);

  localparam int unsigned Entries  = 2 ** INDEX_WIDTH;
  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

  logic                  valid_q  [Entries];
  logic [TagWidth-1:0]   tag_q    [Entries];
  logic [ADDR_WIDTH-1:0] target_q [Entries];
  logic [1:0]            ctr_q    [Entries];

  logic [INDEX_WIDTH-1:0] fetch_idx, upd_idx;
  logic [TagWidth-1:0]    fetch_tag, upd_tag;
  logic                   fetch_hit, upd_hit;
  logic                   miss;
  logic [ADDR_WIDTH-1:0]  correct_pc;
  logic [1:0]             ctr_upd;

  logic                  mispredict_q;
  logic [ADDR_WIDTH-1:0] redirect_q;
  logic [31:0]           branch_count_q, miss_count_q;

  // Word-offset bits never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetchPC[1:0], updPC[1:0]};

  assign fetch_idx = fetchPC[INDEX_WIDTH+1:2];
  assign fetch_tag = fetchPC[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign upd_idx   = updPC[INDEX_WIDTH+1:2];
  assign upd_tag   = updPC[ADDR_WIDTH-1:INDEX_WIDTH+2];

  assign fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign predTaken  = fetch_hit && ctr_q[fetch_idx][1];
  assign predTarget = predTaken ? target_q[fetch_idx] : fetchPC + ADDR_WIDTH'(4);

  assign miss = updValid && ((updTaken != updPredTaken) ||
                             (updTaken && (updTarget != updPredTarget)));
  assign correct_pc = updTaken ? updTarget : updPC + ADDR_WIDTH'(4);

  always_comb begin
    ctr_upd = ctr_q[upd_idx];
    if (updTaken && (ctr_q[upd_idx] != 2'd3)) begin
      ctr_upd = ctr_q[upd_idx] + 2'd1;
    end else if (!updTaken && (ctr_q[upd_idx] != 2'd0)) begin
      ctr_upd = ctr_q[upd_idx] - 2'd1;
    end
  end

  // Flush drops only valid bits; targets and counters survive for reuse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        valid_q[INDEX_WIDTH'(i)]  <= 1'b0;
        tag_q[INDEX_WIDTH'(i)]    <= '0;
        target_q[INDEX_WIDTH'(i)] <= '0;
        ctr_q[INDEX_WIDTH'(i)]    <= 2'd1;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        valid_q[INDEX_WIDTH'(i)] <= 1'b0;
      end
    end else if (updValid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_upd;
        if (updTaken) begin
          target_q[upd_idx] <= updTarget;
        end
      end else if (updTaken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= updTarget;
        ctr_q[upd_idx]    <= 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mispredict_q   <= 1'b0;
      redirect_q     <= '0;
      branch_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      mispredict_q <= miss;
      if (miss) begin
        redirect_q <= correct_pc;
      end
      if (updValid && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (miss && (miss_count_q != '1)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign mispredict  = mispredict_q;
  assign redirectPC  = redirect_q;
  assign branchCount = branch_count_q;
  assign missCount   = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: updates push expected redirect/statistics into a scoreboard that a
// separate monitor drains one edge later; predictions are checked directly.
module tb_branch_predictor;

  logic        clk;
  logic        rstN;
  logic [31:0] fetchPC;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        flush;
  logic        updValid;
  logic [31:0] updPC;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredTarget;
  logic        mispredict;
  logic [31:0] redirectPC;
  logic [31:0] branchCount;
  logic [31:0] missCount;

  branch_predictor #(
    .ADDR_WIDTH  (32),
    .INDEX_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .fetchPC       (fetchPC),
    .predTaken     (predTaken),
    .predTarget    (predTarget),
    .flush         (flush),
    .updValid      (updValid),
    .updPC         (updPC),
    .updTaken      (updTaken),
    .updTarget     (updTarget),
    .updPredTaken  (updPredTaken),
    .updPredTarget (updPredTarget),
    .mispredict    (mispredict),
    .redirectPC    (redirectPC),
    .branchCount   (branchCount),
    .missCount     (missCount)
  );

  typedef struct {
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: an update sampled on this edge must show its response just after it.
  always @(posedge clk) begin
    logic sampled;
    exp_t e;
    sampled = rstN && updValid;
    #1;
    if (rstN) begin
      if (sampled) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got update response, expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
          check("redirect_pc", redirectPC, e.redir);
          check("branch_count", branchCount, e.bc);
          check("miss_count", missCount, e.mc);
        end
      end else begin
        check("idle_mispredict", {31'd0, mispredict}, 32'd0);
      end
    end
  end

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg, input logic fl,
                     input logic emis, input logic [31:0] ered, input logic [31:0] ebc,
                     input logic [31:0] emc);
    exp_t e;
    updValid      = 1'b1;
    updPC         = pc;
    updTaken      = tk;
    updTarget     = tg;
    updPredTaken  = ptk;
    updPredTarget = ptg;
    flush         = fl;
    e.mis = emis; e.redir = ered; e.bc = ebc; e.mc = emc;
    sb.push_back(e);
    @(negedge clk);
    updValid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pred(input logic [31:0] pc, input logic et, input logic [31:0] etg);
    fetchPC = pc;
    #1;
    check("pred_taken", {31'd0, predTaken}, {31'd0, et});
    check("pred_target", predTarget, etg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN = 1'b0; fetchPC = 32'h100; flush = 1'b0; updValid = 1'b0;
    updPC = '0; updTaken = 1'b0; updTarget = '0; updPredTaken = 1'b0; updPredTarget = '0;
    #1;
    check("rst_pred_taken", {31'd0, predTaken}, 32'd0);
    check("rst_pred_target", predTarget, 32'h104);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_redirect", redirectPC, 32'd0);
    check("rst_branch_count", branchCount, 32'd0);
    check("rst_miss_count", missCount, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Allocate 0x100 -> 0x200, then train it up and down through saturation.
    upd(32'h100, 1, 32'h200, 0, 32'h104, 0, 1, 32'h200, 1, 1);
    pred(32'h100, 1, 32'h200);
    upd(32'h100, 1, 32'h200, 1, 32'h200, 0, 0, 32'h200, 2, 1);
    pred(32'h100, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 1, 32'h200, 0, 1, 32'h104, 3, 2);
    pred(32'h100, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 1, 32'h200, 0, 1, 32'h104, 4, 3);
    pred(32'h100, 0, 32'h104);
    upd(32'h100, 0, 32'h0, 0, 32'h104, 0, 0, 32'h104, 5, 3);
    pred(32'h100, 0, 32'h104);
    // Back-to-back: hold at 0, then one taken leaves ctr=1 (still not taken).
    upd(32'h100, 0, 32'h0, 0, 32'h104, 0, 0, 32'h104, 6, 3);
    upd(32'h100, 1, 32'h200, 0, 32'h104, 0, 1, 32'h200, 7, 4);
    pred(32'h100, 0, 32'h104);

    // Alias at 0x140 replaces 0x100; fetch in the same cycle sees the old table.
    pred(32'h140, 0, 32'h144);
    updValid = 1'b1; updPC = 32'h140; updTaken = 1'b1; updTarget = 32'h300;
    updPredTaken = 1'b0; updPredTarget = 32'h144;
    begin
      exp_t e;
      e.mis = 1'b1; e.redir = 32'h300; e.bc = 8; e.mc = 5;
      sb.push_back(e);
    end
    #2;
    check("same_cycle_pred_taken", {31'd0, predTaken}, 32'd0);
    check("same_cycle_pred_target", predTarget, 32'h144);
    @(negedge clk);
    updValid = 1'b0;
    pred(32'h100, 0, 32'h104);
    pred(32'h140, 1, 32'h300);

    // Not-taken miss leaves the table alone; target mismatch mispredicts.
    upd(32'h104, 0, 32'h0, 0, 32'h108, 0, 0, 32'h300, 9, 5);
    pred(32'h104, 0, 32'h108);
    upd(32'h140, 1, 32'h340, 1, 32'h300, 0, 1, 32'h340, 10, 6);
    pred(32'h140, 1, 32'h340);

    // Fall-through PC wraps at the top of the address space.
    upd(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 0, 1, 32'h0, 11, 7);
    pred(32'hFFFF_FFFC, 0, 32'h0);

    // Flush beats training, but statistics and the pulse still follow the update.
    upd(32'h140, 1, 32'h340, 0, 32'h144, 1, 1, 32'h340, 12, 8);
    pred(32'h140, 0, 32'h144);
    upd(32'h108, 1, 32'h400, 0, 32'h10C, 0, 1, 32'h400, 13, 9);
    pred(32'h108, 1, 32'h400);

    // Reset during a mispredicting update: everything clears at once, nothing registers.
    updValid = 1'b1; updPC = 32'h108; updTaken = 1'b1; updTarget = 32'h500;
    updPredTaken = 1'b0; updPredTarget = 32'h10C;
    #1;
    rstN = 1'b0;
    #1;
    check("arst_mispredict", {31'd0, mispredict}, 32'd0);
    check("arst_redirect", redirectPC, 32'd0);
    check("arst_branch_count", branchCount, 32'd0);
    check("arst_miss_count", missCount, 32'd0);
    check("arst_pred_taken", {31'd0, predTaken}, 32'd0);
    check("arst_pred_target", predTarget, 32'h10C);
    @(posedge clk);
    #1;
    check("arst_hold_mispredict", {31'd0, mispredict}, 32'd0);
    check("arst_hold_branch_count", branchCount, 32'd0);
    @(negedge clk);
    updValid = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
